// File: rtl/credit_tx.sv
// credit_tx: sending end of a credit-based link.
// Words from an upstream valid/ready stream go into a 2-entry in-order
// buffer. A buffered word is written to the remote receiver, using a
// single-cycle strobe, only while credit remains. The receiver returns
// one credit each time it pops a word.
// Optional statistics counters are enabled by defining CREDIT_TX_STAT_EN.
// When the macro is not defined, stat_sent and stat_stall are tied to zero.
module credit_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             link_up,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_we,
  input  logic             credit_rtn,
  output logic [7:0]       credit_cnt,
  output logic             err_ovf,
  output logic             idle,
  output logic [31:0]      stat_sent,
  output logic [31:0]      stat_stall
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);

  state_t           state_r;
  logic [WIDTH-1:0] buf_mem_r [2];
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic [1:0]       count_r;

  logic             push_s;
  logic             pop_s;
  logic             ret_s;
  logic [7:0]       credit_next_s;
  logic             ovf_set_s;

  // Readiness depends only on registered state, so it never loops back through s_valid.
  assign s_ready = (count_r < 2'd2) && (state_r != ST_INIT);
  assign idle    = (state_r == ST_RUN) && (count_r == 2'd0) && (credit_cnt == CREDIT_MAX);

  // Decide the push, send and credit-return events for this edge.
  always_comb begin
    push_s = s_valid & s_ready;
    // A link drop seen at this edge already blocks the send.
    pop_s  = (state_r == ST_RUN) && link_up && (count_r != 2'd0) && (credit_cnt != 8'd0);
    ret_s  = credit_rtn && (state_r == ST_RUN);
  end

  // Compute the next credit count and detect a return that would exceed the maximum.
  always_comb begin
    credit_next_s = credit_cnt;
    ovf_set_s     = 1'b0;
    case (state_r)
      ST_HALT: begin
        // When the link comes back up, the receiver has been reset and its buffer is empty again.
        if (link_up) begin
          credit_next_s = CREDIT_MAX;
        end else begin
          credit_next_s = credit_cnt;
        end
      end
      ST_RUN: begin
        if (pop_s && !ret_s) begin
          credit_next_s = credit_cnt - 8'd1;
        end else if (ret_s && !pop_s) begin
          if (credit_cnt == CREDIT_MAX) begin
            ovf_set_s = 1'b1;
          end else begin
            credit_next_s = credit_cnt + 8'd1;
          end
        end else begin
          credit_next_s = credit_cnt;
        end
      end
      default: begin
        credit_next_s = credit_cnt;
      end
    endcase
  end

  // Link state machine with registered write strobe, data, credit count and sticky error.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_r    <= ST_INIT;
      tx_we      <= 1'b0;
      tx_data    <= '0;
      credit_cnt <= CREDIT_MAX;
      err_ovf    <= 1'b0;
    end else begin
      credit_cnt <= credit_next_s;
      if (ovf_set_s) begin
        err_ovf <= 1'b1;
      end
      if (pop_s) begin
        tx_we   <= 1'b1;
        tx_data <= buf_mem_r[rd_ptr_r];
      end else begin
        tx_we   <= 1'b0;
      end
      case (state_r)
        ST_INIT: if (link_up)  state_r <= ST_RUN;
        ST_RUN:  if (!link_up) state_r <= ST_HALT;
        ST_HALT: if (link_up)  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // Buffer pointers and occupancy. A reset drops any buffered words.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage. Its contents only matter while count_r marks them as valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_mem_r[wr_ptr_r] <= s_data;
    end
  end

`ifdef CREDIT_TX_STAT_EN
  logic stall_s;
  assign stall_s = (state_r == ST_RUN) && (count_r != 2'd0) && (credit_cnt == 8'd0);

  // Free-running statistics: words sent, and cycles that have data waiting but no credit.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      stat_sent  <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (pop_s)   stat_sent  <= stat_sent + 32'd1;
      if (stall_s) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_sent  = 32'd0;
  assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: directed scenarios plus randomized
// traffic, compared against a transaction-level queue model.
module tb_credit_tx;

  localparam int CR = 8;
`ifdef CREDIT_TX_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif
  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset_p = 1'b0, link_up = 1'b0, s_valid = 1'b0, credit_rtn = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, tx_we, err_ovf, idle;
  logic [7:0]  tx_data, credit_cnt;
  logic [31:0] stat_sent, stat_stall;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          m_st;
  logic [7:0]  m_q[$];
  int          m_cred;
  bit          m_we, m_ovf, m_acc;
  logic [7:0]  m_data;
  logic [31:0] m_sent, m_stall;

  credit_tx #(.WIDTH(8), .CREDITS(CR)) dut (
    .clk(clk), .reset_p(reset_p), .link_up(link_up),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_data(tx_data), .tx_we(tx_we), .credit_rtn(credit_rtn),
    .credit_cnt(credit_cnt), .err_ovf(err_ovf), .idle(idle),
    .stat_sent(stat_sent), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model by one edge, then move to 1 ns after the edge.
  task automatic tick(input bit rst, input bit lu, input bit v, input logic [7:0] d, input bit cr);
    bit rdy, snd, ret;
    reset_p = rst; link_up = lu; s_valid = v; s_data = d; credit_rtn = cr;
    if (rst) begin
      m_st = M_INIT; m_q.delete(); m_cred = CR; m_we = 0; m_data = 8'd0;
      m_ovf = 0; m_sent = 32'd0; m_stall = 32'd0; m_acc = 0;
    end else begin
      rdy = (m_q.size() < 2) && (m_st != M_INIT);
      snd = (m_st == M_RUN) && lu && (m_q.size() > 0) && (m_cred > 0);
      ret = cr && (m_st == M_RUN);
      if (m_st == M_RUN && m_q.size() > 0 && m_cred == 0) m_stall = m_stall + 32'd1;
      m_acc = v && rdy;
      if (snd) begin
        m_we = 1; m_data = m_q.pop_front(); m_sent = m_sent + 32'd1;
      end else begin
        m_we = 0;
      end
      if (m_acc) m_q.push_back(d);
      case (m_st)
        M_INIT: if (lu) m_st = M_RUN;
        M_RUN: begin
          m_cred = m_cred - int'(snd) + int'(ret);
          if (m_cred > CR) begin m_cred = CR; m_ovf = 1; end
          if (!lu) m_st = M_HALT;
        end
        default: if (lu) begin m_st = M_RUN; m_cred = CR; end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 8'd0, 0);
    tick(1, 0, 0, 8'd0, 0);
    n_checks++; if (tx_we !== 1'b0) begin n_errors++; $display("FAIL reset_tx_we: got %b expected 0", tx_we); end
    n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (credit_cnt !== 8'd8) begin n_errors++; $display("FAIL reset_credit: got %0d expected 8", credit_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err_ovf); end
    n_checks++; if (idle !== 1'b0) begin n_errors++; $display("FAIL reset_idle: got %b expected 0", idle); end
  endtask

  task automatic test_basic();
    logic [7:0] words[3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready_run: got %b expected 1", s_ready); end
    tick(0, 1, 1, words[0], 0);
    n_checks++; if (tx_we !== 1'b0) begin n_errors++; $display("FAIL basic_latency: got tx_we %b expected 0", tx_we); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, (i < 2), (i < 2) ? words[i+1] : 8'd0, 0);
      n_checks++;
      if (tx_we !== 1'b1 || tx_data !== words[i]) begin
        n_errors++; $display("FAIL basic_send%0d: got we=%b data=%h expected we=1 data=%h", i, tx_we, tx_data, words[i]);
      end
    end
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (tx_we !== 1'b0) begin n_errors++; $display("FAIL basic_end: got tx_we %b expected 0", tx_we); end
    n_checks++; if (credit_cnt !== 8'd5) begin n_errors++; $display("FAIL basic_credit: got %0d expected 5", credit_cnt); end
  endtask

  task automatic test_starve();
    int pushed = 0;
    int pulses = 0;
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, (pushed < 12), 8'(8'h40 + pushed), 0);
      if (m_acc) pushed++;
      if (tx_we === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 8) begin n_errors++; $display("FAIL starve_pulses: got %0d expected 8", pulses); end
    n_checks++; if (credit_cnt !== 8'd0) begin n_errors++; $display("FAIL starve_credit: got %0d expected 0", credit_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL starve_ready: got %b expected 0", s_ready); end
    n_checks++; if (pushed != 10) begin n_errors++; $display("FAIL starve_accepted: got %0d expected 10", pushed); end
    n_checks++;
    if (stat_stall !== (STAT_ON ? 32'd11 : 32'd0)) begin
      n_errors++; $display("FAIL starve_stall: got %0d expected %0d", stat_stall, STAT_ON ? 11 : 0);
    end
    pulses = 0;
    tick(0, 1, (pushed < 12), 8'(8'h40 + pushed), 1);
    if (m_acc) pushed++;
    if (tx_we === 1'b1) pulses++;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, (pushed < 12), 8'(8'h40 + pushed), 0);
      if (m_acc) pushed++;
      if (tx_we === 1'b1) begin
        pulses++;
        n_checks++; if (tx_data !== 8'h48) begin n_errors++; $display("FAIL starve_word: got %h expected 48", tx_data); end
      end
    end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL starve_one_more: got %0d expected 1", pulses); end
    n_checks++; if (credit_cnt !== 8'd0) begin n_errors++; $display("FAIL starve_credit2: got %0d expected 0", credit_cnt); end
    n_checks++;
    if (stat_sent !== (STAT_ON ? 32'd9 : 32'd0)) begin
      n_errors++; $display("FAIL starve_sent: got %0d expected %0d", stat_sent, STAT_ON ? 9 : 0);
    end
  endtask

  task automatic test_same_edge();
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 8'(i), 0);
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (credit_cnt !== 8'd3) begin n_errors++; $display("FAIL same_pre: got %0d expected 3", credit_cnt); end
    tick(0, 1, 1, 8'h5A, 0);
    tick(0, 1, 0, 8'd0, 1);
    n_checks++;
    if (tx_we !== 1'b1 || tx_data !== 8'h5A) begin
      n_errors++; $display("FAIL same_send: got we=%b data=%h expected we=1 data=5a", tx_we, tx_data);
    end
    n_checks++; if (credit_cnt !== 8'd3) begin n_errors++; $display("FAIL same_credit: got %0d expected 3", credit_cnt); end
    n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL same_err: got %b expected 0", err_ovf); end
  endtask

  task automatic test_ovf();
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL ovf_idle: got %b expected 1", idle); end
    tick(0, 1, 0, 8'd0, 1);
    n_checks++; if (err_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
    n_checks++; if (credit_cnt !== 8'd8) begin n_errors++; $display("FAIL ovf_credit: got %0d expected 8", credit_cnt); end
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (err_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
    tick(1, 1, 0, 8'd0, 0);
    n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", err_ovf); end
  endtask

  task automatic test_halt();
    int bad_we = 0;
    int bad_cr = 0;
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 8'(8'h60 + i), 0);
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (credit_cnt !== 8'd2) begin n_errors++; $display("FAIL halt_pre_credit: got %0d expected 2", credit_cnt); end
    tick(0, 0, 1, 8'hA1, 0);
    if (tx_we !== 1'b0) bad_we++;
    tick(0, 0, 1, 8'hB2, 1);
    if (tx_we !== 1'b0) bad_we++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 8'd0, (i != 1));
      if (tx_we !== 1'b0) bad_we++;
      if (credit_cnt !== 8'd2) bad_cr++;
    end
    n_checks++; if (bad_we != 0) begin n_errors++; $display("FAIL halt_no_send: got %0d strobes expected 0", bad_we); end
    n_checks++; if (bad_cr != 0) begin n_errors++; $display("FAIL halt_credit_ignored: got %0d bad cycles expected 0", bad_cr); end
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (credit_cnt !== 8'd8) begin n_errors++; $display("FAIL halt_reload: got %0d expected 8", credit_cnt); end
    n_checks++; if (tx_we !== 1'b0) begin n_errors++; $display("FAIL halt_resume_edge: got %b expected 0", tx_we); end
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (tx_we !== 1'b1 || tx_data !== 8'hA1) begin n_errors++; $display("FAIL halt_word0: got we=%b data=%h expected we=1 data=a1", tx_we, tx_data); end
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (tx_we !== 1'b1 || tx_data !== 8'hB2) begin n_errors++; $display("FAIL halt_word1: got we=%b data=%h expected we=1 data=b2", tx_we, tx_data); end
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (credit_cnt !== 8'd6) begin n_errors++; $display("FAIL halt_post_credit: got %0d expected 6", credit_cnt); end
  endtask

  task automatic test_reset_mid();
    tick(1, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    for (int i = 0; i < 14; i++) tick(0, 1, 1, 8'(8'h70 + i), 0);
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL mid_full: got s_ready %b expected 0", s_ready); end
    tick(1, 1, 1, 8'hEE, 0);
    n_checks++; if (tx_we !== 1'b0) begin n_errors++; $display("FAIL mid_tx_we: got %b expected 0", tx_we); end
    n_checks++; if (credit_cnt !== 8'd8) begin n_errors++; $display("FAIL mid_credit: got %0d expected 8", credit_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready: got %b expected 0", s_ready); end
    n_checks++; if (stat_sent !== 32'd0 || stat_stall !== 32'd0) begin n_errors++; $display("FAIL mid_stats: got %0d/%0d expected 0/0", stat_sent, stat_stall); end
    tick(0, 1, 0, 8'd0, 0);
    tick(0, 1, 0, 8'd0, 0);
    n_checks++; if (idle !== 1'b1 || tx_we !== 1'b0) begin n_errors++; $display("FAIL mid_empty: got idle=%b we=%b expected idle=1 we=0", idle, tx_we); end
  endtask

  task automatic test_random();
    bit ready_exp, idle_exp;
    tick(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           8'($urandom), ($urandom_range(0, 2) == 0));
      ready_exp = (m_q.size() < 2) && (m_st != M_INIT);
      idle_exp  = (m_st == M_RUN) && (m_q.size() == 0) && (m_cred == CR);
      n_checks++; if (tx_we !== m_we) begin n_errors++; $display("FAIL rnd_we cyc %0d: got %b expected %b", i, tx_we, m_we); end
      n_checks++; if (tx_data !== m_data) begin n_errors++; $display("FAIL rnd_data cyc %0d: got %h expected %h", i, tx_data, m_data); end
      n_checks++; if (credit_cnt !== 8'(m_cred)) begin n_errors++; $display("FAIL rnd_credit cyc %0d: got %0d expected %0d", i, credit_cnt, m_cred); end
      n_checks++; if (s_ready !== ready_exp) begin n_errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", i, s_ready, ready_exp); end
      n_checks++; if (err_ovf !== m_ovf) begin n_errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", i, err_ovf, m_ovf); end
      n_checks++; if (idle !== idle_exp) begin n_errors++; $display("FAIL rnd_idle cyc %0d: got %b expected %b", i, idle, idle_exp); end
      n_checks++; if (stat_sent !== (STAT_ON ? m_sent : 32'd0)) begin n_errors++; $display("FAIL rnd_sent cyc %0d: got %0d expected %0d", i, stat_sent, STAT_ON ? m_sent : 32'd0); end
      n_checks++; if (stat_stall !== (STAT_ON ? m_stall : 32'd0)) begin n_errors++; $display("FAIL rnd_stall cyc %0d: got %0d expected %0d", i, stat_stall, STAT_ON ? m_stall : 32'd0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_same_edge();
    test_ovf();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
